// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/RUN/HALT sequencer driving a combinational ROM,
// with a 16-entry branch-target table and a one-bubble taken-branch redirect.
module fetch_unit #(
   parameter int unsigned         PC_W    = 10,
   parameter int unsigned         INSTR_W = 9,
   parameter logic [INSTR_W-1:0]  HALT_OP = '1
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Stall,
   input  logic               Branch,
   input  logic               Taken,
   input  logic [3:0]         TargetIdx,
   input  logic               LutWe,
   input  logic [3:0]         LutAddr,
   input  logic [PC_W-1:0]    LutData,
   output logic [PC_W-1:0]    Imem_addr,
   input  logic [INSTR_W-1:0] Imem_data,
   output logic [INSTR_W-1:0] Instr,
   output logic               InstrValid,
   output logic [PC_W-1:0]    PC,
   output logic               Done
);

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_t;

   state_t          state_q;
   logic [PC_W-1:0] fetch_pc_q;
   logic [PC_W-1:0] lut_q [16];
   logic            halt_hit;
   logic            redirect;
   logic            lut_wr;

   assign Imem_addr = fetch_pc_q;
   assign halt_hit  = InstrValid && (Instr == HALT_OP);
   assign redirect  = InstrValid && Branch && Taken;
   assign lut_wr    = LutWe && (state_q != StRun);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= StIdle;
         fetch_pc_q <= '0;
         Instr      <= '0;
         PC         <= '0;
         InstrValid <= 1'b0;
         Done       <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (Start) begin
                  state_q    <= StRun;
                  fetch_pc_q <= '0;
               end
            end
            StRun: begin
               // Stall freezes everything; halt outranks redirect.
               if (!Stall) begin
                  if (halt_hit) begin
                     state_q    <= StHalt;
                     InstrValid <= 1'b0;
                     Done       <= 1'b1;
                  end else if (redirect) begin
                     fetch_pc_q <= lut_q[TargetIdx];
                     InstrValid <= 1'b0;
                  end else begin
                     Instr      <= Imem_data;
                     PC         <= fetch_pc_q;
                     fetch_pc_q <= fetch_pc_q + 1'b1;
                     InstrValid <= 1'b1;
                  end
               end
            end
            StHalt: begin
               if (Start) begin
                  state_q    <= StRun;
                  fetch_pc_q <= '0;
                  Done       <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 16; i++) lut_q[i] <= '0;
      end else if (lut_wr) begin
         lut_q[LutAddr] <= LutData;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: halt program, branches, stall, reset and PC wrap.
module tb_fetch_unit;

   localparam int unsigned PC_W    = 10;
   localparam int unsigned INSTR_W = 9;
   localparam logic [INSTR_W-1:0] HALT = '1;

   logic               Clk;
   logic               Reset;
   logic               Start;
   logic               Stall;
   logic               Branch;
   logic               Taken;
   logic [3:0]         TargetIdx;
   logic               LutWe;
   logic [3:0]         LutAddr;
   logic [PC_W-1:0]    LutData;
   logic [PC_W-1:0]    Imem_addr;
   logic [INSTR_W-1:0] Imem_data;
   logic [INSTR_W-1:0] Instr;
   logic               InstrValid;
   logic [PC_W-1:0]    PC;
   logic               Done;

   logic [INSTR_W-1:0] rom [1024];
   int n_tests = 0;
   int n_fail  = 0;

   assign Imem_data = rom[Imem_addr];

   fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .HALT_OP(HALT)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .Stall      (Stall),
      .Branch     (Branch),
      .Taken      (Taken),
      .TargetIdx  (TargetIdx),
      .LutWe      (LutWe),
      .LutAddr    (LutAddr),
      .LutData    (LutData),
      .Imem_addr  (Imem_addr),
      .Imem_data  (Imem_data),
      .Instr      (Instr),
      .InstrValid (InstrValid),
      .PC         (PC),
      .Done       (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic wait_pc(input logic [PC_W-1:0] target, input int budget);
      int n = 0;
      while (!(InstrValid && PC == target) && n < budget) begin
         tick();
         n++;
      end
      check("reach_pc", {31'd0, (InstrValid && PC == target)}, 32'd1);
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = {1'b0, i[7:0]};
      rom[0] = 9'h001;
      rom[1] = 9'h002;
      rom[2] = 9'h003;
      rom[3] = HALT;
      Reset = 1'b0; Start = 1'b0; Stall = 1'b0; Branch = 1'b0; Taken = 1'b0;
      TargetIdx = '0; LutWe = 1'b0; LutAddr = '0; LutData = '0;
      @(negedge Clk);
      tick();
      check("rst_valid", {31'd0, InstrValid}, 32'd0);
      check("rst_done",  {31'd0, Done}, 32'd0);
      check("rst_addr",  {22'd0, Imem_addr}, 32'd0);
      check("rst_instr", {23'd0, Instr}, 32'd0);
      Reset = 1'b1;
      tick(); tick();
      check("idle_hold", {31'd0, InstrValid}, 32'd0);

      // Four-instruction program ending in HALT
      pulse_start();
      check("start_bubble", {31'd0, InstrValid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("prog_valid", {31'd0, InstrValid}, 32'd1);
         check("prog_pc", {22'd0, PC}, i);
         check("prog_instr", {23'd0, Instr}, {23'd0, rom[i]});
      end
      tick();
      check("halt_done",  {31'd0, Done}, 32'd1);
      check("halt_valid", {31'd0, InstrValid}, 32'd0);
      tick(); tick();
      check("halt_hold", {31'd0, Done}, 32'd1);
      pulse_start();
      check("restart_done", {31'd0, Done}, 32'd0);
      tick();
      check("restart_pc", {22'd0, PC}, 32'd0);
      check("restart_instr", {23'd0, Instr}, 32'h001);
      rom[3] = 9'h003;

      // Reset clears everything; load table in IDLE
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      LutWe = 1'b1; LutAddr = 4'd2; LutData = 10'h040;
      tick();
      LutAddr = 4'd1; LutData = 10'h005;
      tick();
      LutWe = 1'b0;
      pulse_start();

      // Not-taken branch at PC 5, then Start ignored in RUN
      wait_pc(10'h005, 20);
      Branch = 1'b1; Taken = 1'b0; TargetIdx = 4'd2;
      tick();
      Branch = 1'b0;
      check("nt_pc", {22'd0, PC}, 32'h006);
      check("nt_valid", {31'd0, InstrValid}, 32'd1);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      check("start_in_run", {22'd0, PC}, 32'h007);

      // Taken branch 7 -> LUT[1]=5, then 5 -> LUT[2]=0x40
      Branch = 1'b1; Taken = 1'b1; TargetIdx = 4'd1;
      tick();
      Branch = 1'b0;
      check("br1_bubble", {31'd0, InstrValid}, 32'd0);
      tick();
      check("br1_pc", {22'd0, PC}, 32'h005);
      Branch = 1'b1; Taken = 1'b1; TargetIdx = 4'd2;
      tick();
      Branch = 1'b0;
      check("br2_bubble", {31'd0, InstrValid}, 32'd0);
      tick();
      check("br2_pc", {22'd0, PC}, 32'h040);
      check("br2_instr", {23'd0, Instr}, 32'h040);

      // LutWe in RUN must not change the table
      LutWe = 1'b1; LutAddr = 4'd2; LutData = 10'h0aa;
      tick();
      LutWe = 1'b0;
      check("lutwe_run_pc", {22'd0, PC}, 32'h041);
      Branch = 1'b1; Taken = 1'b1; TargetIdx = 4'd2;
      tick();
      Branch = 1'b0;
      tick();
      check("lut_protect", {22'd0, PC}, 32'h040);

      // Stall for three cycles with a taken branch presented
      Branch = 1'b1; Taken = 1'b1; TargetIdx = 4'd1; Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc", {22'd0, PC}, 32'h040);
         check("stall_valid", {31'd0, InstrValid}, 32'd1);
      end
      Stall = 1'b0;
      tick();
      Branch = 1'b0;
      check("stall_redir_bubble", {31'd0, InstrValid}, 32'd0);
      tick();
      check("stall_redir_pc", {22'd0, PC}, 32'h005);

      // Asynchronous reset mid-RUN at PC 0x1FF
      wait_pc(10'h1ff, 1200);
      Reset = 1'b0;
      #1;
      check("arst_pc", {22'd0, PC}, 32'd0);
      check("arst_addr", {22'd0, Imem_addr}, 32'd0);
      check("arst_instr", {23'd0, Instr}, 32'd0);
      check("arst_valid", {31'd0, InstrValid}, 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      tick(); tick();
      check("post_rst_idle", {31'd0, InstrValid}, 32'd0);
      check("post_rst_addr", {22'd0, Imem_addr}, 32'd0);
      pulse_start();
      tick();
      check("rerun_pc", {22'd0, PC}, 32'd0);
      check("rerun_instr", {23'd0, Instr}, 32'h001);

      // Cleared table: taken branch via index 2 lands on 0
      Branch = 1'b1; Taken = 1'b1; TargetIdx = 4'd2;
      tick();
      Branch = 1'b0;
      tick();
      check("lut_cleared", {22'd0, PC}, 32'd0);

      // Wrap past 0x3FF
      wait_pc(10'h3ff, 1100);
      tick();
      check("wrap_pc", {22'd0, PC}, 32'd0);
      check("wrap_valid", {31'd0, InstrValid}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 10: program counter width in bits.
REQ-002 Parameter INSTR_W, default 9: instruction width in bits.
REQ-003 Parameter HALT_OP, default all-ones of INSTR_W bits: halt instruction encoding.
REQ-004 Clk  in  1  clock; all state updates on the rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset (low = reset asserted).
REQ-006 Start  in  1  level; begins program execution from address 0.
REQ-007 Stall  in  1  downstream hold; freezes all fetch state.
REQ-008 Branch  in  1  from the control decoder; current Instr is a branch.
REQ-009 Taken  in  1  branch condition from the ALU; valid with Branch.
REQ-010 TargetIdx  in  4  index into the branch-target table.
REQ-011 LutWe, LutAddr[3:0], LutData[PC_W-1:0]  in  table write port.
REQ-012 Imem_addr  out  PC_W  fetch address to the combinational instruction ROM.
REQ-013 Imem_data  in  INSTR_W  ROM data for Imem_addr, same cycle.
REQ-014 Instr  out  INSTR_W  registered instruction presented to the decoder.
REQ-015 InstrValid  out  1  Instr is valid for execution.
REQ-016 PC  out  PC_W  address Instr was fetched from.
REQ-017 Done  out  1  program halted.

Function
REQ-018 States: IDLE, RUN, HALT; Imem_addr = internal FetchPC in every state.
REQ-019 IDLE: Start=1 -> RUN, FetchPC<=0; InstrValid=0 throughout IDLE.
REQ-020 RUN, Stall=0, no redirect: Instr<=Imem_data, PC<=FetchPC, FetchPC<=FetchPC+1, InstrValid<=1.
REQ-021 FetchPC wraps modulo 2^PC_W; no error flag.
REQ-022 Redirect = InstrValid & Branch & Taken & ~Stall: FetchPC<=LUT[TargetIdx], InstrValid<=0 for the next cycle (one bubble); Instr/PC content during the bubble is don't-care.
REQ-023 Branch=1 with Taken=0: sequential fetch per REQ-020.
REQ-024 Branch/Taken are ignored when InstrValid=0.
REQ-025 Stall=1 in RUN: FetchPC, Instr, PC, InstrValid hold; Stall takes priority over redirect and halt; the pending action completes on the first cycle with Stall=0.
REQ-026 Halt: InstrValid=1 & Instr==HALT_OP & ~Stall -> HALT next cycle, InstrValid<=0, Done<=1; halt takes priority over redirect.
REQ-027 HALT: all fetch state holds; Done=1; Start=1 -> RUN with FetchPC<=0, Done<=0.
REQ-028 Start is ignored in RUN.
REQ-029 LUT: 16 entries x PC_W bits; written when LutWe=1 in IDLE or HALT; LutWe ignored in RUN.
REQ-030 Latency: instruction at address A appears on Instr one cycle after Imem_addr=A.

Reset
REQ-031 Reset low, at any time including mid-RUN: state=IDLE, FetchPC=0, Instr=0, PC=0, InstrValid=0, Done=0, all LUT entries=0, asynchronously.
REQ-032 After Reset deasserts, the block leaves IDLE only on Start.

Verification
REQ-033 ROM[0..3]=0x01,0x02,0x03,HALT_OP; Start pulse -> Instr 0x01,0x02,0x03,HALT_OP on consecutive cycles with PC 0..3, then Done=1, InstrValid=0.
REQ-034 LUT[2]=0x040 written in IDLE; branch at PC=5 with Taken=1, TargetIdx=2 -> one InstrValid=0 bubble, then PC=0x040.
REQ-035 Branch=1, Taken=0 at PC=5 -> PC=6 next cycle, no bubble.
REQ-036 Stall=1 for 3 cycles while a taken branch is presented -> Instr/PC held for 3 cycles; redirect occurs on the cycle after Stall drops.
REQ-037 Reset driven low mid-RUN at PC=0x1FF -> outputs zero immediately; Start restarts at PC=0; with PC_W=10, sequential fetch past 0x3FF wraps to 0x000.
REQ-038 LutWe=1 during RUN -> LUT unchanged, verified by a subsequent taken branch.
